// File: rtl/cic_decimate_output.sv
// cic_decimate_output: decimates filtered stereo samples by DECIM, applies one comb stage with a gain shift,
// and queues the results in a show-ahead FIFO that feeds the codec write port.
module cic_decimate_output #(
   parameter int DATA_W     = 24,
   parameter int DECIM      = 8,
   parameter int SHIFT      = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               CLOCK_50,
   input  logic                               reset,
   input  logic                               in_valid,
   input  logic [DATA_W-1:0]                  in_left,
   input  logic [DATA_W-1:0]                  in_right,
   input  logic                               write_ready,
   output logic                               write,
   output logic [DATA_W-1:0]                  writedata_left,
   output logic [DATA_W-1:0]                  writedata_right,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
   output logic                               overflow
);
   localparam int PW = $clog2(DECIM);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   logic [PW-1:0] phase;
   logic take, y_valid, full, push, pop;
   logic signed [DATA_W-1:0] prev_l, prev_r, d_l, d_r, y_l, y_r;
   logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   assign take = in_valid && phase == PW'(DECIM-1);
   // Differences wrap modulo 2^DATA_W on purpose
   assign d_l = in_left - prev_l;
   assign d_r = in_right - prev_r;
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         phase   <= '0;
         prev_l  <= '0;
         prev_r  <= '0;
         y_l     <= '0;
         y_r     <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= take;
         if (in_valid) phase <= take ? '0 : phase + 1'b1;
         if (take) begin
            prev_l <= in_left;
            prev_r <= in_right;
            y_l    <= d_l >>> SHIFT;
            y_r    <= d_r >>> SHIFT;
         end
      end
   end
   assign full  = fifo_level == LW'(FIFO_DEPTH);
   assign write = |fifo_level && write_ready;
   assign pop   = write;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push  = y_valid && (!full || pop);
   assign writedata_left  = |fifo_level ? mem_l[rd_ptr] : '0;
   assign writedata_right = |fifo_level ? mem_r[rd_ptr] : '0;
   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         mem_l[wr_ptr] <= y_l;
         mem_r[wr_ptr] <= y_r;
      end
   end
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
         overflow   <= overflow | (y_valid && full && !pop);
      end
   end
endmodule

// File: tb/tb_cic_decimate_output.sv
// tb_cic_decimate_output: directed and randomized checks of cic_decimate_output against a queue-based model.
module tb_cic_decimate_output;
   localparam int DW = 24;
   localparam int R  = 8;
   localparam int SH = 3;
   localparam int D  = 4;
   logic CLOCK_50 = 1'b0, reset = 1'b1, in_valid = 1'b0, write_ready = 1'b0;
   logic [DW-1:0] in_left = '0, in_right = '0;
   logic write, overflow;
   logic [DW-1:0] writedata_left, writedata_right;
   logic [$clog2(D+1)-1:0] fifo_level;
   int checks = 0, failures = 0;
   cic_decimate_output #(.DATA_W(DW), .DECIM(R), .SHIFT(SH), .FIFO_DEPTH(D)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .in_valid(in_valid), .in_left(in_left), .in_right(in_right),
      .write_ready(write_ready), .write(write), .writedata_left(writedata_left),
      .writedata_right(writedata_right), .fifo_level(fifo_level), .overflow(overflow));
   always #10 CLOCK_50 = ~CLOCK_50;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Model: count strobes, every R-th one produces a comb result that lands in the queue two edges later
   typedef struct {int due; logic [2*DW-1:0] v;} pend_t;
   logic [2*DW-1:0] mq[$];
   pend_t pq[$];
   logic [DW-1:0] got[$];
   int cyc = 0, strobes = 0;
   logic [DW-1:0] xl = '0, xr = '0;
   logic movf = 1'b0;
   bit chk_en = 0;
   function automatic logic [DW-1:0] comb(input logic [DW-1:0] x, input logic [DW-1:0] p);
      logic signed [DW-1:0] d;
      d = x - p;
      return d >>> SH;
   endfunction
   always @(posedge CLOCK_50) begin
      if (reset) begin
         mq.delete();
         pq.delete();
         strobes = 0;
         xl = '0;
         xr = '0;
         movf = 1'b0;
      end else begin
         if (mq.size() > 0 && write_ready) void'(mq.pop_front());
         while (pq.size() > 0 && pq[0].due == cyc) begin
            if (mq.size() < D) mq.push_back(pq[0].v);
            else movf = 1'b1;
            void'(pq.pop_front());
         end
         if (in_valid) begin
            strobes++;
            if (strobes % R == 0) begin
               pq.push_back('{cyc + 1, {comb(in_left, xl), comb(in_right, xr)}});
               xl = in_left;
               xr = in_right;
            end
         end
      end
      cyc++;
   end
   logic [2*DW-1:0] head;
   always @(negedge CLOCK_50) begin
      if (chk_en) begin
         head = mq.size() > 0 ? mq[0] : '0;
         check("write", 32'(write), 32'(mq.size() > 0 && write_ready));
         check("wd_left", 32'(writedata_left), 32'(head[2*DW-1:DW]));
         check("wd_right", 32'(writedata_right), 32'(head[DW-1:0]));
         check("level", 32'(fifo_level), 32'(mq.size()));
         check("overflow", 32'(overflow), 32'(movf));
         if (write) got.push_back(writedata_left);
      end
   end
   task automatic tick(input bit iv, input bit wr, input logic [DW-1:0] l, input logic [DW-1:0] r);
      in_valid = iv;
      write_ready = wr;
      in_left = l;
      in_right = r;
      @(posedge CLOCK_50);
      #1;
   endtask
   task automatic feed(input int n, input logic [DW-1:0] l, input logic [DW-1:0] r, input int gap, input bit wr);
      for (int i = 0; i < n; i++) begin
         tick(1, wr, l, r);
         repeat (gap) tick(0, wr, l, r);
      end
   endtask
   task automatic idle(input int n, input bit wr);
      repeat (n) tick(0, wr, '0, '0);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      tick(0, 0, '0, '0);
      reset = 1'b0;
      chk_en = 1;
      got.delete();
   endtask
   initial begin
      do_reset();
      check("rst_level", 32'(fifo_level), 0);
      check("rst_write", 32'(write), 0);
      // Constant input: one startup step, then silence
      feed(24, 24'd800, 24'd1600, 3, 1);
      idle(4, 1);
      check("const_n", got.size(), 3);
      check("const_0", 32'(got[0]), 100);
      check("const_1", 32'(got[1]), 0);
      check("const_2", 32'(got[2]), 0);
      // Negative step exercises sign extension
      do_reset();
      feed(40, '0, '0, 0, 1);
      feed(16, -24'sd800, 24'd8, 0, 1);
      idle(4, 1);
      check("step_n", got.size(), 7);
      check("step_5", 32'(got[5]), 32'h00FFFF9C);
      check("step_6", 32'(got[6]), 0);
      // Modular wrap of the difference
      do_reset();
      feed(8, 24'h7FFFF0, 24'h7FFFF0, 0, 1);
      feed(8, 24'h800010, 24'h800010, 0, 1);
      idle(4, 1);
      check("wrap_0", 32'(got[0]), 32'h000FFFFE);
      check("wrap_1", 32'(got[1]), 4);
      check("wrap_ovf", 32'(overflow), 0);
      // Overflow: five results into a stalled four-entry FIFO
      do_reset();
      for (int k = 1; k <= 5; k++) feed(8, DW'(8 * k), DW'(8 * k), 0, 0);
      idle(3, 0);
      check("ovf_level", 32'(fifo_level), 4);
      check("ovf_flag", 32'(overflow), 1);
      idle(8, 1);
      check("ovf_n", got.size(), 4);
      for (int i = 0; i < 4; i++) check("ovf_data", 32'(got[i]), 1);
      check("ovf_drained", 32'(fifo_level), 0);
      // Full FIFO with a pop in the exact push cycle
      do_reset();
      for (int k = 1; k <= 4; k++) feed(8, DW'(8 * k), DW'(8 * k), 0, 0);
      idle(3, 0);
      feed(7, 24'd72, 24'd72, 0, 0);
      tick(1, 0, 24'd72, 24'd72);
      tick(0, 1, '0, '0);
      tick(0, 0, '0, '0);
      check("fullpop_level", 32'(fifo_level), 4);
      check("fullpop_ovf", 32'(overflow), 0);
      idle(8, 1);
      check("fullpop_n", got.size(), 5);
      check("fullpop_last", 32'(got[4]), 5);
      // Reset mid-stream with level 3 and phase 5
      do_reset();
      for (int k = 1; k <= 3; k++) feed(8, DW'(8 * k), DW'(8 * k), 0, 0);
      idle(2, 0);
      feed(5, 24'd99, 24'd99, 0, 0);
      check("pre_rst_level", 32'(fifo_level), 3);
      reset = 1'b1;
      tick(0, 1, '0, '0);
      check("mrst_level", 32'(fifo_level), 0);
      check("mrst_write", 32'(write), 0);
      check("mrst_wd", 32'(writedata_left), 0);
      check("mrst_ovf", 32'(overflow), 0);
      reset = 1'b0;
      got.delete();
      feed(7, 24'd800, 24'd800, 0, 1);
      idle(3, 1);
      check("mrst_early", got.size(), 0);
      feed(1, 24'd800, 24'd800, 0, 1);
      idle(3, 1);
      check("mrst_n", got.size(), 1);
      check("mrst_first", 32'(got[0]), 100);
      // Randomized traffic with two back-pressure profiles and rare resets
      do_reset();
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 2500; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 9) < (s == 0 ? 6 : 1), DW'($urandom), DW'($urandom));
         end
      end
      reset = 1'b0;
      idle(20, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
